// File: rtl/interconnect_four_data_to_sfft.sv
// Gather stage: collects four parallel sub-FFT lanes into a buffer, then replays
// them column by column (lane0[k]..lane3[k]) to a radix-4 FFT paced by its wait flag.
module interconnect_four_data_to_sfft #(
  parameter int SIZE_BUFFER   = 4,
  parameter int DATA_FFT_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid0,
  input  logic                     valid1,
  input  logic                     valid2,
  input  logic                     valid3,
  input  logic [DATA_FFT_SIZE-1:0] data_fft0_i,
  input  logic [DATA_FFT_SIZE-1:0] data_fft1_i,
  input  logic [DATA_FFT_SIZE-1:0] data_fft2_i,
  input  logic [DATA_FFT_SIZE-1:0] data_fft3_i,
  input  logic [DATA_FFT_SIZE-1:0] data_fft0_q,
  input  logic [DATA_FFT_SIZE-1:0] data_fft1_q,
  input  logic [DATA_FFT_SIZE-1:0] data_fft2_q,
  input  logic [DATA_FFT_SIZE-1:0] data_fft3_q,
  output logic                     flag_ready_recive,
  input  logic                     fft_wayt_data,
  output logic [DATA_FFT_SIZE-1:0] out_data_i,
  output logic [DATA_FFT_SIZE-1:0] out_data_q,
  output logic                     outvalid,
  output logic [SIZE_BUFFER-3:0]   out_group,
  output logic                     overflow
);

  localparam int AW = SIZE_BUFFER - 2;
  localparam int PW = SIZE_BUFFER - 1;
  localparam int L  = 1 << AW;
  localparam int DW = DATA_FFT_SIZE;
  localparam int SW = 2 * DATA_FFT_SIZE;
  localparam logic [PW-1:0] LANE_LEN = PW'(L);
  localparam logic [AW-1:0] G_LAST   = '1;

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SEND, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wp_q [4];
  logic [PW-1:0]   wp_d [4];
  logic [AW-1:0]   g_q, g_d;
  logic [1:0]      s_q, s_d;
  logic            flag_q, flag_d;
  logic            outvalid_q, outvalid_d;
  logic [DW-1:0]   out_i_q, out_i_d;
  logic [DW-1:0]   out_q_q, out_q_d;
  logic [AW-1:0]   out_group_q, out_group_d;
  logic            overflow_q, overflow_d;

  logic            lane_valid [4];
  logic [SW-1:0]   lane_data  [4];
  logic            wr_en      [4];
  logic            all_full;
  logic [SW-1:0]   rd_word;
  logic [SW-1:0]   mem [4][L];

  always_comb begin
    lane_valid = '{valid0, valid1, valid2, valid3};
    lane_data  = '{{data_fft0_i, data_fft0_q}, {data_fft1_i, data_fft1_q},
                   {data_fft2_i, data_fft2_q}, {data_fft3_i, data_fft3_q}};
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    g_d         = g_q;
    s_d         = s_q;
    outvalid_d  = 1'b0;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_group_d = out_group_q;
    overflow_d  = overflow_q;
    all_full    = 1'b1;
    rd_word     = mem[s_q][g_q];
    for (int unsigned n = 0; n < 4; n++) wr_en[n] = 1'b0;

    case (state_q)
      ST_LOAD: begin
        for (int unsigned n = 0; n < 4; n++) begin
          if (lane_valid[n]) begin
            if (wp_q[n] < LANE_LEN) begin
              wr_en[n] = 1'b1;
              wp_d[n]  = wp_q[n] + PW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        // Full-detect looks at the post-write pointers so the last write and the move coincide.
        for (int unsigned n = 0; n < 4; n++) begin
          if (wp_d[n] != LANE_LEN) all_full = 1'b0;
        end
        if (all_full) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        s_d = 2'd0;
        if (fft_wayt_data) state_d = ST_SEND;
      end
      ST_SEND: begin
        outvalid_d  = 1'b1;
        out_i_d     = rd_word[SW-1:DW];
        out_q_d     = rd_word[DW-1:0];
        out_group_d = g_q;
        s_d         = s_q + 2'd1;
        if (s_q == 2'd3) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (g_q != G_LAST) begin
          g_d     = g_q + AW'(1);
          state_d = ST_WAIT;
        end else begin
          g_d     = '0;
          for (int unsigned n = 0; n < 4; n++) wp_d[n] = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    flag_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      for (int unsigned n = 0; n < 4; n++) wp_q[n] <= '0;
      g_q         <= '0;
      s_q         <= '0;
      flag_q      <= 1'b1;
      outvalid_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_group_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      g_q         <= g_d;
      s_q         <= s_d;
      flag_q      <= flag_d;
      outvalid_q  <= outvalid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_group_q <= out_group_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 4; n++) begin
      if (wr_en[n]) mem[n][wp_q[n][AW-1:0]] <= lane_data[n];
    end
  end

  assign flag_ready_recive = flag_q;
  assign outvalid          = outvalid_q;
  assign out_data_i        = out_i_q;
  assign out_data_q        = out_q_q;
  assign out_group         = out_group_q;
  assign overflow          = overflow_q;

endmodule
